memory_stage: RTL and testbench

- Pipeline MEM stage of the 5-stage RV32 core; sits directly upstream of the Writeback stage and drives its wb_* inputs through the MEM/WB register it owns.
- Issues load/store requests to data memory over a valid/ready request plus response-valid handshake.
- Aligns and sign/zero-extends load data, forms store byte strobes, and stalls the upstream pipeline while a transaction is outstanding.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/load_align.sv | 23 ++
 rtl/memory_stage.sv | 140 ++++++++++++++
 tb/tb_memory_stage.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the MEM stage (funct3 sizes, writeback selects, FSM states)
// and the store lane helpers used when building a data-memory request.
package mem_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] MTR_PC  = 2'd0;
    localparam logic [1:0] MTR_MEM = 2'd1;
    localparam logic [1:0] MTR_ALU = 2'd2;
    localparam logic [1:0] MTR_CSR = 2'd3;

    typedef enum logic {IDLE, WAIT_RSP} state_t;

    // funct3[1:0]: 00 byte, 01 half, 1x word
    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
        return f3[1] ? 4'b1111 : f3[0] ? 4'b0011 << {a[1], 1'b0} : 4'b0001 << a;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        return f3[1] ? d : f3[0] ? {2{d[15:0]}} : {4{d[7:0]}};
    endfunction
endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/half out of a raw read word and sign- or zero-extends it;
// undefined load sizes fall through as a whole word.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rsp_data,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;

    assign b = rsp_data[{addr, 3'b000} +: 8];
    assign h = rsp_data[{addr[1], 4'b0000} +: 16];

    always_comb begin
        data = funct3 == F3_LB  ? {{24{b[7]}}, b} :
               funct3 == F3_LH  ? {{16{h[15]}}, h} :
               funct3 == F3_LBU ? {24'b0, b} :
               funct3 == F3_LHU ? {16'b0, h} : rsp_data;
    end
endmodule

// File: rtl/memory_stage.sv
// memory_stage: RV32 MEM stage owning the MEM/WB register; one outstanding data access at a time.
// Define MEM_MISALIGN_TRAP_EN to drop misaligned half/word accesses and pulse io_misalign.
module memory_stage
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_ex_valid,
    input  logic [XLEN-1:0] io_ex_aluresult,
    input  logic [XLEN-1:0] io_ex_storedata,
    input  logic            io_ex_memread,
    input  logic            io_ex_memwrite,
    input  logic [2:0]      io_ex_funct3,
    input  logic [1:0]      io_ex_memtoreg,
    input  logic [XLEN-1:0] io_ex_reg_pc,
    input  logic [4:0]      io_ex_rd,
    input  logic            io_ex_regwrite,
    input  logic            io_flush,
    output logic            io_stall,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic            io_misalign,
`endif
    output logic            io_dmem_req_valid,
    input  logic            io_dmem_req_ready,
    output logic [XLEN-1:0] io_dmem_addr,
    output logic            io_dmem_we,
    output logic [3:0]      io_dmem_wstrb,
    output logic [XLEN-1:0] io_dmem_wdata,
    input  logic            io_dmem_rsp_valid,
    input  logic [XLEN-1:0] io_dmem_rsp_data,
    output logic            io_wb_valid,
    output logic            io_wb_regwrite,
    output logic [XLEN-1:0] io_wb_aluresult,
    output logic [XLEN-1:0] io_wb_readdata,
    output logic [XLEN-1:0] io_wb_reg_pc,
    output logic [1:0]      io_wb_memtoreg,
    output logic [4:0]      io_wb_rd
);
    state_t          state;
    logic [1:0]      cap_addr;
    logic [2:0]      cap_funct3;
    logic            cap_store;
    logic [1:0]      cap_memtoreg;
    logic [XLEN-1:0] cap_pc;
    logic [XLEN-1:0] cap_alu;
    logic [4:0]      cap_rd;
    logic            cap_regwrite;
    logic            ex_live;
    logic            mem_op;
    logic            misalign;
    logic            issue;
    logic [XLEN-1:0] load_data;

    assign ex_live = io_ex_valid & ~io_flush;
    assign mem_op  = ex_live & (io_ex_memread | io_ex_memwrite);
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = mem_op & (io_ex_funct3[1] ? |io_ex_aluresult[1:0]
                                                : io_ex_funct3[0] & io_ex_aluresult[0]);
`else
    assign misalign = 1'b0;
`endif
    assign issue = mem_op & ~misalign;

    assign io_dmem_req_valid = state == IDLE && issue;
    assign io_stall          = state == IDLE ? issue & ~io_dmem_req_ready : ~io_dmem_rsp_valid;
    assign io_dmem_addr      = {io_ex_aluresult[XLEN-1:2], 2'b00};
    assign io_dmem_we        = io_ex_memwrite;
    assign io_dmem_wstrb     = io_ex_memwrite ? store_strb(io_ex_funct3, io_ex_aluresult[1:0]) : 4'b0000;
    assign io_dmem_wdata     = store_data(io_ex_funct3, io_ex_storedata);

    load_align u_load_align (
        .rsp_data (io_dmem_rsp_data),
        .addr     (cap_addr),
        .funct3   (cap_funct3),
        .data     (load_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cap_addr        <= '0;
            cap_funct3      <= '0;
            cap_store       <= 1'b0;
            cap_memtoreg    <= '0;
            cap_pc          <= '0;
            cap_alu         <= '0;
            cap_rd          <= '0;
            cap_regwrite    <= 1'b0;
            io_wb_valid     <= 1'b0;
            io_wb_regwrite  <= 1'b0;
            io_wb_aluresult <= '0;
            io_wb_readdata  <= '0;
            io_wb_reg_pc    <= '0;
            io_wb_memtoreg  <= '0;
            io_wb_rd        <= '0;
        end else if (io_stall) begin
            io_wb_valid    <= 1'b0;
            io_wb_regwrite <= 1'b0;
        end else if (state == WAIT_RSP) begin
            state           <= IDLE;
            io_wb_valid     <= 1'b1;
            io_wb_regwrite  <= cap_regwrite;
            io_wb_aluresult <= cap_alu;
            io_wb_readdata  <= cap_store ? '0 : load_data;
            io_wb_reg_pc    <= cap_pc;
            io_wb_memtoreg  <= cap_memtoreg;
            io_wb_rd        <= cap_rd;
        end else if (issue) begin
            // request accepted this edge: the instruction retires later, so MEM/WB takes a bubble now
            state          <= WAIT_RSP;
            cap_addr       <= io_ex_aluresult[1:0];
            cap_funct3     <= io_ex_funct3;
            cap_store      <= io_ex_memwrite;
            cap_memtoreg   <= io_ex_memtoreg;
            cap_pc         <= io_ex_reg_pc;
            cap_alu        <= io_ex_aluresult;
            cap_rd         <= io_ex_rd;
            cap_regwrite   <= io_ex_regwrite;
            io_wb_valid    <= 1'b0;
            io_wb_regwrite <= 1'b0;
        end else begin
            io_wb_valid     <= ex_live & ~misalign;
            io_wb_regwrite  <= ex_live & ~misalign & io_ex_regwrite;
            io_wb_aluresult <= io_ex_aluresult;
            io_wb_readdata  <= '0;
            io_wb_reg_pc    <= io_ex_reg_pc;
            io_wb_memtoreg  <= io_ex_memtoreg;
            io_wb_rd        <= io_ex_rd;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) io_misalign <= 1'b0;
        else        io_misalign <= state == IDLE && misalign;
    end
`endif
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed vectors for memory_stage; expected requests and writebacks are queued
// at issue time and a negedge monitor pops and compares them whenever the DUT presents one.
module tb_memory_stage;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_ex_valid = 1'b0;
    logic [31:0] io_ex_aluresult = '0;
    logic [31:0] io_ex_storedata = '0;
    logic        io_ex_memread = 1'b0;
    logic        io_ex_memwrite = 1'b0;
    logic [2:0]  io_ex_funct3 = '0;
    logic [1:0]  io_ex_memtoreg = '0;
    logic [31:0] io_ex_reg_pc = '0;
    logic [4:0]  io_ex_rd = '0;
    logic        io_ex_regwrite = 1'b0;
    logic        io_flush = 1'b0;
    logic        io_stall;
    logic        io_misalign;
    logic        io_dmem_req_valid;
    logic        io_dmem_req_ready = 1'b0;
    logic [31:0] io_dmem_addr;
    logic        io_dmem_we;
    logic [3:0]  io_dmem_wstrb;
    logic [31:0] io_dmem_wdata;
    logic        io_dmem_rsp_valid = 1'b0;
    logic [31:0] io_dmem_rsp_data = '0;
    logic        io_wb_valid;
    logic        io_wb_regwrite;
    logic [31:0] io_wb_aluresult;
    logic [31:0] io_wb_readdata;
    logic [31:0] io_wb_reg_pc;
    logic [1:0]  io_wb_memtoreg;
    logic [4:0]  io_wb_rd;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        chk_rdata;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  mtr;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

    wb_t  wb_q[$];
    req_t req_q[$];
    wb_t  ew;
    req_t er;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    memory_stage dut (
        .clock             (clock),
        .reset             (reset),
        .io_ex_valid       (io_ex_valid),
        .io_ex_aluresult   (io_ex_aluresult),
        .io_ex_storedata   (io_ex_storedata),
        .io_ex_memread     (io_ex_memread),
        .io_ex_memwrite    (io_ex_memwrite),
        .io_ex_funct3      (io_ex_funct3),
        .io_ex_memtoreg    (io_ex_memtoreg),
        .io_ex_reg_pc      (io_ex_reg_pc),
        .io_ex_rd          (io_ex_rd),
        .io_ex_regwrite    (io_ex_regwrite),
        .io_flush          (io_flush),
        .io_stall          (io_stall),
`ifdef MEM_MISALIGN_TRAP_EN
        .io_misalign       (io_misalign),
`endif
        .io_dmem_req_valid (io_dmem_req_valid),
        .io_dmem_req_ready (io_dmem_req_ready),
        .io_dmem_addr      (io_dmem_addr),
        .io_dmem_we        (io_dmem_we),
        .io_dmem_wstrb     (io_dmem_wstrb),
        .io_dmem_wdata     (io_dmem_wdata),
        .io_dmem_rsp_valid (io_dmem_rsp_valid),
        .io_dmem_rsp_data  (io_dmem_rsp_data),
        .io_wb_valid       (io_wb_valid),
        .io_wb_regwrite    (io_wb_regwrite),
        .io_wb_aluresult   (io_wb_aluresult),
        .io_wb_readdata    (io_wb_readdata),
        .io_wb_reg_pc      (io_wb_reg_pc),
        .io_wb_memtoreg    (io_wb_memtoreg),
        .io_wb_rd          (io_wb_rd)
    );

`ifndef MEM_MISALIGN_TRAP_EN
    assign io_misalign = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (io_wb_valid) begin
                if (wb_q.size() == 0) chk("wb_unexpected", io_wb_valid, 0);
                else begin
                    ew = wb_q.pop_front();
                    chk("wb_alu", io_wb_aluresult, ew.alu);
                    if (ew.chk_rdata) chk("wb_readdata", io_wb_readdata, ew.rdata);
                    chk("wb_pc", io_wb_reg_pc, ew.pc);
                    chk("wb_rd", io_wb_rd, ew.rd);
                    chk("wb_regwrite", io_wb_regwrite, ew.rw);
                    chk("wb_memtoreg", io_wb_memtoreg, ew.mtr);
                end
            end
            if (io_dmem_req_valid && io_dmem_req_ready) begin
                if (req_q.size() == 0) chk("req_unexpected", io_dmem_req_valid, 0);
                else begin
                    er = req_q.pop_front();
                    chk("req_addr", io_dmem_addr, er.addr);
                    chk("req_we", io_dmem_we, er.we);
                    chk("req_wstrb", io_dmem_wstrb, er.strb);
                    if (er.we) chk("req_wdata", io_dmem_wdata, er.wdata);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd_, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] pc,
                         input logic [4:0] rd, input logic rw, input logic [1:0] mtr);
        io_ex_valid = v; io_ex_memread = rd_; io_ex_memwrite = wr; io_ex_funct3 = f3;
        io_ex_aluresult = a; io_ex_storedata = sd; io_ex_reg_pc = pc;
        io_ex_rd = rd; io_ex_regwrite = rw; io_ex_memtoreg = mtr;
    endtask

    task automatic idle_ex();
        drive(0, 0, 0, 3'd0, 0, 0, 0, 5'd0, 0, 2'd0);
    endtask

    // one load/store: ready after rdy wait cycles, response after rsp wait cycles
    task automatic mem_txn(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input int rdy, input int rsp,
                           input logic [31:0] rdata, input logic [31:0] exp_rd,
                           input logic [3:0] strb, input logic [31:0] wdata, input logic fl);
        drive(1, ~wr, wr, f3, a, sd, 32'h1000 + a, 5'd9, ~wr, wr ? 2'd2 : 2'd1);
        req_q.push_back('{addr: {a[31:2], 2'b00}, we: wr, strb: strb, wdata: wdata});
        wb_q.push_back('{alu: a, rdata: exp_rd, chk_rdata: 1'b1, pc: 32'h1000 + a, rd: 5'd9,
                         rw: ~wr, mtr: wr ? 2'd2 : 2'd1});
        io_dmem_req_ready = 1'b0;
        for (int i = 0; i < rdy; i++) begin
            @(negedge clock);
            chk("stall_wait_ready", io_stall, 1);
            chk("req_valid_held", io_dmem_req_valid, 1);
            step();
        end
        io_dmem_req_ready = 1'b1;
        @(negedge clock);
        chk("stall_on_accept", io_stall, 0);
        step();
        io_dmem_req_ready = 1'b0;
        idle_ex();
        if (fl) drive(1, 1, 0, 3'd2, 32'h40, 0, 0, 5'd3, 1, 2'd1);
        io_flush = fl;
        for (int i = 0; i < rsp; i++) begin
            @(negedge clock);
            chk("stall_wait_rsp", io_stall, 1);
            chk("no_req_in_wait", io_dmem_req_valid, 0);
            step();
        end
        io_dmem_rsp_valid = 1'b1;
        io_dmem_rsp_data = rdata;
        @(negedge clock);
        chk("stall_on_rsp", io_stall, 0);
        step();
        io_dmem_rsp_valid = 1'b0;
        io_dmem_rsp_data = '0;
        io_flush = 1'b0;
        idle_ex();
    endtask

    initial begin
        #12;
        chk("rst_wb_valid", io_wb_valid, 0);
        chk("rst_stall", io_stall, 0);
        chk("rst_req_valid", io_dmem_req_valid, 0);
        chk("rst_wb_alu", io_wb_aluresult, 0);
        chk("rst_misalign", io_misalign, 0);
        reset = 1'b1;
        step();

        drive(1, 0, 0, 3'd0, 32'h1234, 0, 32'h40, 5'd5, 1, 2'd2);
        wb_q.push_back('{alu: 32'h1234, rdata: 0, chk_rdata: 1'b0, pc: 32'h40, rd: 5'd5, rw: 1'b1, mtr: 2'd2});
        @(negedge clock);
        chk("alu_stall", io_stall, 0);
        chk("alu_no_req", io_dmem_req_valid, 0);
        step();
        idle_ex();
        @(negedge clock);
        chk("alu_wb_valid", io_wb_valid, 1);
        chk("alu_wb_alu", io_wb_aluresult, 32'h1234);
        step();

        mem_txn(0, 3'b000, 32'h103, 0, 0, 3, 32'h80FF_FFFF, 32'hFFFF_FF80, 4'b0000, 0, 0);
        mem_txn(0, 3'b101, 32'h102, 0, 0, 0, 32'hBEEF_0000, 32'h0000_BEEF, 4'b0000, 0, 0);
        mem_txn(1, 3'b000, 32'h201, 32'hAB, 2, 1, 0, 0, 4'b0010, 32'hABAB_ABAB, 0);
        mem_txn(0, 3'b001, 32'h102, 0, 0, 1, 32'h8001_0000, 32'hFFFF_8001, 4'b0000, 0, 0);
        mem_txn(0, 3'b100, 32'h101, 0, 1, 0, 32'h0000_9A00, 32'h0000_009A, 4'b0000, 0, 0);
        mem_txn(0, 3'b010, 32'h104, 0, 0, 0, 32'h1234_5678, 32'h1234_5678, 4'b0000, 0, 0);
        mem_txn(1, 3'b001, 32'h202, 32'h5555_1234, 0, 0, 0, 0, 4'b1100, 32'h1234_1234, 0);
        mem_txn(1, 3'b010, 32'h300, 32'hDEAD_BEEF, 1, 2, 0, 0, 4'b1111, 32'hDEAD_BEEF, 0);
        mem_txn(0, 3'b111, 32'h108, 0, 0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b0000, 0, 0);
        mem_txn(0, 3'b010, 32'h10, 0, 0, 2, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 4'b0000, 0, 1);

        drive(1, 1, 0, 3'd2, 32'h400, 0, 32'h80, 5'd4, 1, 2'd1);
        io_flush = 1'b1;
        io_dmem_req_ready = 1'b1;
        @(negedge clock);
        chk("flush_no_req", io_dmem_req_valid, 0);
        chk("flush_no_stall", io_stall, 0);
        step();
        io_flush = 1'b0;
        io_dmem_req_ready = 1'b0;
        idle_ex();
        io_dmem_rsp_valid = 1'b1;
        io_dmem_rsp_data = 32'hFFFF_FFFF;
        @(negedge clock);
        chk("flush_wb_valid", io_wb_valid, 0);
        chk("idle_rsp_no_stall", io_stall, 0);
        step();
        io_dmem_rsp_valid = 1'b0;
        @(negedge clock);
        chk("idle_rsp_ignored", io_wb_valid, 0);
        step();

        drive(1, 0, 0, 3'd0, 32'h77, 0, 32'h88, 5'd12, 1, 2'd2);
        wb_q.push_back('{alu: 32'h77, rdata: 0, chk_rdata: 1'b0, pc: 32'h88, rd: 5'd12, rw: 1'b1, mtr: 2'd2});
        step();
        drive(1, 1, 0, 3'd2, 32'h500, 0, 32'h8C, 5'd13, 1, 2'd1);
        req_q.push_back('{addr: 32'h500, we: 1'b0, strb: 4'b0000, wdata: 0});
        io_dmem_req_ready = 1'b1;
        step();
        io_dmem_req_ready = 1'b0;
        idle_ex();
        @(negedge clock);
        chk("pre_reset_stall", io_stall, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_wb_alu", io_wb_aluresult, 0);
        chk("arst_wb_pc", io_wb_reg_pc, 0);
        chk("arst_wb_rd", io_wb_rd, 0);
        chk("arst_wb_memtoreg", io_wb_memtoreg, 0);
        chk("arst_stall", io_stall, 0);
        #1 reset = 1'b1;
        step();
        io_dmem_rsp_valid = 1'b1;
        io_dmem_rsp_data = 32'h1111_2222;
        @(negedge clock);
        chk("post_reset_idle_stall", io_stall, 0);
        step();
        io_dmem_rsp_valid = 1'b0;
        @(negedge clock);
        chk("post_reset_no_wb", io_wb_valid, 0);
        step();

`ifdef MEM_MISALIGN_TRAP_EN
        drive(1, 1, 0, 3'd2, 32'h2, 0, 32'h90, 5'd14, 1, 2'd1);
        io_dmem_req_ready = 1'b1;
        @(negedge clock);
        chk("mis_no_req", io_dmem_req_valid, 0);
        chk("mis_no_stall", io_stall, 0);
        step();
        io_dmem_req_ready = 1'b0;
        idle_ex();
        @(negedge clock);
        chk("mis_pulse", io_misalign, 1);
        chk("mis_bubble", io_wb_valid, 0);
        chk("mis_regwrite", io_wb_regwrite, 0);
        step();
        @(negedge clock);
        chk("mis_pulse_end", io_misalign, 0);
        step();
`endif

        repeat (2) step();
        chk("wb_queue_drained", wb_q.size(), 0);
        chk("req_queue_drained", req_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
